// File: rtl/sequential_divider.sv
// sequential_divider: multi-cycle restoring divider, 8-bit dividend by 4-bit
// divisor, one quotient bit per clock, start/done handshake.
//
// Handshake: Start is sampled on the rising edge while the divider is in IDLE
// or DONE (A and B are captured on that same edge); Start during RUN is ignored.
// Done is a one-cycle pulse and Quotient/Remainder/DivZero are valid from that
// cycle until the next completion or reset. Busy and Done are never both high.
//
// Optional feature macro: DIVIDER_DIVZERO_EN. When defined, a zero divisor
// skips the iteration and completes in one cycle with DivZero set. When not
// defined, a zero divisor runs the normal algorithm and DivZero is tied low.
module sequential_divider (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic [7:0] A,
    input  logic [3:0] B,
    output logic [7:0] Quotient,
    output logic [3:0] Remainder,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] dvd_q, dvd_d;     // dividend shift register
    logic [3:0] dvs_q, dvs_d;     // divisor
    logic [3:0] rem_q, rem_d;     // partial remainder (after each step it is < divisor)
    logic [7:0] quo_q, quo_d;     // working quotient
    logic [7:0] quot_q, quot_d;   // output quotient register
    logic [3:0] remd_q, remd_d;   // output remainder register
`ifdef DIVIDER_DIVZERO_EN
    logic       dz_q, dz_d;
`endif

    // One restoring step: 5-bit shifted remainder, compare, conditional subtract.
    logic [4:0] shifted;
    logic       q_bit;
    logic [3:0] rem_step;
    logic [7:0] quo_step;
    logic       accept;

    // Datapath step for the current RUN cycle.
    always_comb begin
        shifted  = {rem_q, dvd_q[7]};
        q_bit    = (shifted >= {1'b0, dvs_q});
        // When the compare succeeds the difference is < divisor, so only its low
        // four bits are meaningful; with a zero divisor the low bits are still exact.
        rem_step = q_bit ? (shifted[3:0] - dvs_q) : shifted[3:0];
        quo_step = {quo_q[6:0], q_bit};
    end

    // Next-state and next-register logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
`ifdef DIVIDER_DIVZERO_EN
        dz_d    = dz_q;
`endif
        accept  = Start && (state_q != S_RUN);

        case (state_q)
            S_RUN: begin
                dvd_d = {dvd_q[6:0], 1'b0};
                rem_d = rem_step;
                quo_d = quo_step;
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                    quot_d  = quo_step;
                    remd_d  = rem_step;
`ifdef DIVIDER_DIVZERO_EN
                    dz_d    = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            dvd_d   = A;
            dvs_d   = B;
            rem_d   = 4'h0;
            quo_d   = 8'h00;
            cnt_d   = 3'd7;
            state_d = S_RUN;
`ifdef DIVIDER_DIVZERO_EN
            if (B == 4'h0) begin
                state_d = S_DONE;
                cnt_d   = 3'd0;
                quot_d  = 8'hFF;
                remd_d  = A[3:0];
                dz_d    = 1'b1;
            end
`endif
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            dvd_q   <= 8'h00;
            dvs_q   <= 4'h0;
            rem_q   <= 4'h0;
            quo_q   <= 8'h00;
            quot_q  <= 8'h00;
            remd_q  <= 4'h0;
`ifdef DIVIDER_DIVZERO_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
`ifdef DIVIDER_DIVZERO_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign Quotient    = quot_q;
    assign Remainder   = remd_q;
    assign Busy        = (state_q == S_RUN);
    assign Done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;
`ifdef DIVIDER_DIVZERO_EN
    assign DivZero     = dz_q;
`else
    assign DivZero     = 1'b0;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Directed testbench for sequential_divider. Inputs are driven on the falling
// edge, outputs sampled on the falling edge. Honours DIVIDER_DIVZERO_EN.
module tb_sequential_divider;

    logic       Clk;
    logic       Rst;
    logic       Start;
    logic [7:0] A;
    logic [3:0] B;
    logic [7:0] Quotient;
    logic [3:0] Remainder;
    logic       Busy;
    logic       Done;
    logic       DivZero;
    logic [1:0] dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] prev_q;
    logic [3:0] prev_r;

`ifdef DIVIDER_DIVZERO_EN
    localparam int  DZ_LAT  = 1;
    localparam int  DZ_BUSY = 0;
    localparam bit  DZ_FLAG = 1'b1;
`else
    localparam int  DZ_LAT  = 9;
    localparam int  DZ_BUSY = 8;
    localparam bit  DZ_FLAG = 1'b0;
`endif

    sequential_divider dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Start       (Start),
        .A           (A),
        .B           (B),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Busy        (Busy),
        .Done        (Done),
        .DivZero     (DivZero),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drives one request at the current falling edge and follows it until Done.
    // lat = number of falling edges after the request at which Done is first seen
    // (0 on timeout); busy_cnt = cycles with Busy high; bad = cycles where Busy and
    // Done overlap or the held outputs changed before Done.
    task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] hq, input logic [3:0] hr,
                          output int lat, output int busy_cnt, output int bad);
        A = a; B = b; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        lat = 0; busy_cnt = 0; bad = 0;
        for (int k = 1; k <= 20; k++) begin
            if (Busy && Done) bad++;
            if (!Done && (Quotient !== hq || Remainder !== hr)) bad++;
            if (Busy) busy_cnt++;
            if (Done) begin
                lat = k;
                break;
            end
            @(negedge Clk);
        end
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; A = 8'h00; B = 4'h0;
        repeat (2) @(negedge Clk);
        tests_run++;
        if ({Quotient, Remainder, Busy, Done, DivZero, dbg_state} !== 17'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got Q=%h R=%h busy=%b done=%b dz=%b st=%0d required all zero",
                     Quotient, Remainder, Busy, Done, DivZero, dbg_state);
        end
        Rst = 1'b0;
        @(negedge Clk);
        prev_q = 8'h00; prev_r = 4'h0;
    endtask

    task automatic check_result(input string name, input logic [7:0] a, input logic [3:0] b,
                                input logic [7:0] eq, input logic [3:0] er, input logic edz,
                                input int elat, input int ebusy);
        int lat, busy_cnt, bad;
        run_op(a, b, prev_q, prev_r, lat, busy_cnt, bad);
        tests_run++;
        if (lat != elat) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d required %0d", name, lat, elat);
        end
        tests_run++;
        if (busy_cnt != ebusy) begin
            tests_failed++;
            $display("FAIL %s_busy_cycles: got %0d required %0d", name, busy_cnt, ebusy);
        end
        tests_run++;
        if (Quotient !== eq || Remainder !== er) begin
            tests_failed++;
            $display("FAIL %s_result: got Q=%h R=%h required Q=%h R=%h", name, Quotient, Remainder, eq, er);
        end
        tests_run++;
        if (DivZero !== edz) begin
            tests_failed++;
            $display("FAIL %s_divzero: got %b required %b", name, DivZero, edz);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL %s_hold_overlap: got %0d bad cycles required 0", name, bad);
        end
        prev_q = eq; prev_r = er;
    endtask

    task automatic expect_idle_after(input string name);
        @(negedge Clk);
        tests_run++;
        if (Done !== 1'b0 || Busy !== 1'b0 || Quotient !== prev_q || Remainder !== prev_r) begin
            tests_failed++;
            $display("FAIL %s_after_done: got done=%b busy=%b Q=%h R=%h required 0 0 %h %h",
                     name, Done, Busy, Quotient, Remainder, prev_q, prev_r);
        end
    endtask

    task automatic test_basic();
        check_result("c8_div_7", 8'hC8, 4'h7, 8'h1C, 4'h4, 1'b0, 9, 8);
        expect_idle_after("c8_div_7");
        check_result("ff_div_1", 8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 9, 8);
        expect_idle_after("ff_div_1");
        check_result("05_div_9", 8'h05, 4'h9, 8'h00, 4'h5, 1'b0, 9, 8);
        expect_idle_after("05_div_9");
    endtask

    task automatic test_divzero();
        check_result("a7_div_0", 8'hA7, 4'h0, 8'hFF, 4'h7, DZ_FLAG, DZ_LAT, DZ_BUSY);
        expect_idle_after("a7_div_0");
        // A following non-zero division must clear the flag.
        check_result("0f_div_4_after_dz", 8'h0F, 4'h4, 8'h03, 4'h3, 1'b0, 9, 8);
        expect_idle_after("0f_div_4_after_dz");
    endtask

    task automatic test_ignored_start();
        int lat;
        lat = 0;
        A = 8'h64; B = 4'h5; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3) begin
                A = 8'h11; B = 4'h3; Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            if (Done) begin
                lat = k;
                break;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        tests_run++;
        if (lat != 9) begin
            tests_failed++;
            $display("FAIL ignored_start_latency: got %0d required 9", lat);
        end
        tests_run++;
        if (Quotient !== 8'h14 || Remainder !== 4'h0) begin
            tests_failed++;
            $display("FAIL ignored_start_result: got Q=%h R=%h required Q=14 R=0", Quotient, Remainder);
        end
        prev_q = 8'h14; prev_r = 4'h0;
        expect_idle_after("ignored_start");
    endtask

    task automatic test_reset_mid_run();
        int done_seen;
        done_seen = 0;
        A = 8'hC8; B = 4'h7; Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        tests_run++;
        if ({Quotient, Remainder, Busy, Done, DivZero, dbg_state} !== 17'h0) begin
            tests_failed++;
            $display("FAIL midrun_reset_outputs: got Q=%h R=%h busy=%b done=%b dz=%b st=%0d required all zero",
                     Quotient, Remainder, Busy, Done, DivZero, dbg_state);
        end
        for (int k = 0; k < 12; k++) begin
            if (Done || Busy) done_seen++;
            @(negedge Clk);
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++;
            $display("FAIL midrun_reset_no_done: got %0d active cycles required 0", done_seen);
        end
        prev_q = 8'h00; prev_r = 4'h0;
        check_result("0f_div_4_after_rst", 8'h0F, 4'h4, 8'h03, 4'h3, 1'b0, 9, 8);
        expect_idle_after("0f_div_4_after_rst");
    endtask

    task automatic test_back_to_back();
        check_result("b2b_first", 8'hC8, 4'h7, 8'h1C, 4'h4, 1'b0, 9, 8);
        // Start asserted in the Done cycle: accepted immediately.
        check_result("b2b_second", 8'h90, 4'hC, 8'h0C, 4'h0, 1'b0, 9, 8);
        expect_idle_after("b2b_second");
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b0; A = 8'h00; B = 4'h0;
        prev_q = 8'h00; prev_r = 4'h0;
        @(negedge Clk);
        test_reset();
        test_basic();
        test_divzero();
        test_ignored_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
